// File: rtl/stump_io_port.sv
// Memory-mapped I/O port for the Stump bus: byte TX FIFO, status register, prescaled timer.
// Define STUMP_IO_IRQ_EN to add the CTRL register and the registered irq output.
module stump_io_port #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PRESCALE   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] wr_data,
  input  logic        mem_wen,
  input  logic        mem_ren,
  output logic [15:0] rd_data,
  output logic        sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef STUMP_IO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(PRESCALE - 1);
  localparam logic [4:0]     DEPTH_CNT = 5'(FIFO_DEPTH);

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]     count_q, count_d;
  logic           ovf_q, ovf_d, tick_q, tick_d;
  logic [15:0]    timer_q, timer_d, compare_q, compare_d;
  logic [PSW-1:0] presc_q, presc_d;
`ifdef STUMP_IO_IRQ_EN
  logic           irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  logic [2:0] offset;
  logic       wr_en, push, pop, push_ok, full, empty, step;
  // Reads are side-effect free, so the read strobe carries no information here.
  logic       unused_ren;

  assign unused_ren = mem_ren;
  assign offset     = address[2:0];
  assign sel        = (address[15:3] == BASE_ADDR[15:3]);
  assign wr_en      = mem_wen & sel;
  assign empty      = (count_q == 5'd0);
  assign full       = (count_q == DEPTH_CNT);
  assign tx_valid   = ~empty;
  assign tx_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign push       = wr_en && (offset == 3'd0);
  assign pop        = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push && (!full || pop);
  assign step       = (presc_q == PRESC_MAX);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tick_d    = tick_q;
    timer_d   = timer_q;
    compare_d = compare_q;
    presc_d   = step ? '0 : presc_q + 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + 5'(push_ok) - 5'(pop);

    // Clears are applied first so a same-cycle set wins.
    if (wr_en && offset == 3'd1 && wr_data[2]) ovf_d  = 1'b0;
    if (wr_en && offset == 3'd1 && wr_data[3]) tick_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;

    if (wr_en && offset == 3'd2) begin
      timer_d = wr_data;
      presc_d = '0;
    end else if (step) begin
      if (timer_q == compare_q) begin
        timer_d = 16'h0000;
        tick_d  = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end

    if (wr_en && offset == 3'd3) compare_d = wr_data;
  end

`ifdef STUMP_IO_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && offset == 3'd4) irq_en_d = wr_data[0];
    irq_d = tick_q & irq_en_q;
  end
  assign irq = irq_q;
`endif

  always_comb begin
    rd_data = 16'h0000;
    if (sel) begin
      case (offset)
        3'd1: rd_data = {7'd0, count_q, tick_q, ovf_q, full, empty};
        3'd2: rd_data = timer_q;
        3'd3: rd_data = compare_q;
`ifdef STUMP_IO_IRQ_EN
        3'd4: rd_data = {15'd0, irq_en_q};
`endif
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
      timer_q   <= 16'h0000;
      compare_q <= 16'hFFFF;
      presc_q   <= '0;
`ifdef STUMP_IO_IRQ_EN
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tick_q    <= tick_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
`ifdef STUMP_IO_IRQ_EN
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_stump_io_port.sv
// Self-checking bench for stump_io_port; drained TX bytes are checked against a scoreboard queue.
module tb_stump_io_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address, wr_data;
  logic        mem_wen, mem_ren;
  logic [15:0] rd_data;
  logic        sel;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
`ifdef STUMP_IO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  stump_io_port dut (
    .clk(clk), .rst(rst), .address(address), .wr_data(wr_data),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .rd_data(rd_data), .sel(sel),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef STUMP_IO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Every handshake seen just before an edge must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got %h, required no pop", tx_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (tx_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", tx_data, exp);
        end else begin
          $display("pop data=%h", tx_data);
        end
      end
    end
  end

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    address = a;
    wr_data = d;
    mem_wen = 1'b1;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    address = 16'h0000;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    address = a;
    mem_ren = 1'b1;
    #1;
    d = rd_data;
    mem_ren = 1'b0;
    address = 16'h0000;
    $display("read addr=%h data=%h", a, d);
  endtask

  task automatic check_reg(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(a, v);
    checks++;
    if (v !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, v, exp);
    end
  endtask

  task automatic test_reset;
    logic [15:0] addrs [6] = '{16'hFF00, 16'hFF07, 16'hFF08, 16'hFEFF, 16'h1234, 16'hFF03};
    logic        exp_sel [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: got valid=%b data=%h, required 0/00", tx_valid, tx_data);
    end
    check_reg("reset_txdata", 16'hFF00, 16'h0000);
    check_reg("reset_status", 16'hFF01, 16'h0001);
    check_reg("reset_timer", 16'hFF02, 16'h0000);
    check_reg("reset_compare", 16'hFF03, 16'hFFFF);
    check_reg("reset_ctrl", 16'hFF04, 16'h0000);
    check_reg("out_of_window", 16'h1234, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      address = addrs[i];
      #1;
      checks++;
      if (sel !== exp_sel[i]) begin
        errors++;
        $display("FAIL sel_%h: got %b, required %b", addrs[i], sel, exp_sel[i]);
      end
    end
`ifdef STUMP_IO_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b, required 0", irq);
    end
`endif
  endtask

  task automatic test_fill_overflow;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] w;
      w = 16'hAB41 + 16'(i);
      if (i < 4) sb.push_back(w[7:0]);
      bus_write(16'hFF00, w);
    end
    // count 4, full, overflow
    check_reg("full_status", 16'hFF01, 16'h0046);
    checks++;
    if (tx_data !== 8'h41) begin
      errors++;
      $display("FAIL head_byte: got %h, required 41", tx_data);
    end
    tx_ready = 1'b1;
    cycle(4);
    checks++;
    if (tx_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_done: got valid=%b left=%0d, required 0/0", tx_valid, sb.size());
    end
    tx_ready = 1'b0;
    bus_write(16'hFF01, 16'h0004);
    check_reg("overflow_clear", 16'hFF01, 16'h0001);
  endtask

  task automatic test_full_push_pop;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      w = 16'h0061 + 16'(i);
      sb.push_back(w[7:0]);
      bus_write(16'hFF00, w);
    end
    sb.push_back(8'h55);
    tx_ready = 1'b1;
    bus_write(16'hFF00, 16'h0055);
    tx_ready = 1'b0;
    check_reg("full_push_pop_status", 16'hFF01, 16'h0042);
    tx_ready = 1'b1;
    cycle(4);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL push_pop_drain: got valid=%b left=%0d, required 0/0", tx_valid, sb.size());
    end
  endtask

  task automatic test_timer_tick;
`ifdef STUMP_IO_IRQ_EN
    bus_write(16'hFF04, 16'h0001);
    check_reg("ctrl_readback", 16'hFF04, 16'h0001);
`endif
    bus_write(16'hFF03, 16'h0003);
    bus_write(16'hFF02, 16'h0000);
    cycle(63);
    check_reg("tick_not_yet", 16'hFF01, 16'h0001);
    cycle(1);
    check_reg("tick_set", 16'hFF01, 16'h0009);
    check_reg("timer_wrapped", 16'hFF02, 16'h0000);
`ifdef STUMP_IO_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b, required 0", irq);
    end
    cycle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b, required 1", irq);
    end
`endif
    bus_write(16'hFF01, 16'h0008);
    check_reg("tick_clear", 16'hFF01, 16'h0001);
`ifdef STUMP_IO_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: got %b, required 1", irq);
    end
    cycle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop: got %b, required 0", irq);
    end
`endif
  endtask

  task automatic test_timer_write_step;
    bus_write(16'hFF03, 16'hFFFF);
    bus_write(16'hFF02, 16'h0000);
    cycle(15);
    bus_write(16'hFF02, 16'h0100);
    check_reg("timer_write_wins", 16'hFF02, 16'h0100);
    cycle(15);
    check_reg("timer_no_step_yet", 16'hFF02, 16'h0100);
    cycle(1);
    check_reg("timer_stepped", 16'hFF02, 16'h0101);
  endtask

  task automatic test_reset_mid;
    bus_write(16'hFF03, 16'h0000);
    bus_write(16'hFF02, 16'h0000);
    bus_write(16'hFF04, 16'h0001);
    cycle(20);
`ifdef STUMP_IO_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_before_reset: got %b, required 1", irq);
    end
`endif
    tx_ready = 1'b0;
    bus_write(16'hFF00, 16'h0011);
    bus_write(16'hFF00, 16'h0022);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got valid=%b, required 0", tx_valid);
    end
    check_reg("reset_mid_status", 16'hFF01, 16'h0001);
    check_reg("reset_mid_timer", 16'hFF02, 16'h0000);
    check_reg("reset_mid_compare", 16'hFF03, 16'hFFFF);
`ifdef STUMP_IO_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_reset: got %b, required 0", irq);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    address = 16'h0000;
    wr_data = 16'h0000;
    mem_wen = 1'b0;
    mem_ren = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_timer_tick();
    test_timer_write_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
